// File: rtl/seg_display_scan_if.sv
// Segment-scan bus: digit patterns and controls in, multiplexed
// segment/anode drive and frame strobe out.
interface seg_display_scan_if;
  logic       enable;
  logic       blank_lz;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
  logic [6:0] seg_out;
  logic [1:0] an_out;
  logic       frame_done;

  modport master (
    output enable, blank_lz,
    output seg_tens, seg_ones,
    input  seg_out, an_out,
    input  frame_done
  );

  modport slave (
    input  enable, blank_lz,
    input  seg_tens, seg_ones,
    output seg_out, an_out,
    output frame_done
  );
endinterface

// File: rtl/seg_display_scan.sv
// Two-digit seven-segment scanner with optional dead-time
// between digits and leading-zero blanking of the tens digit.
module seg_display_scan #(
  parameter int TICK_DIV       = 62500,
  parameter int BLANK_CYCLES   = 0,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic clk,
  input logic rst_n,
  seg_display_scan_if.slave bus
);

  localparam int MAXN =
    (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
  localparam int CW = $clog2(MAXN + 1);
  localparam bit HAS_BLK = (BLANK_CYCLES > 0);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLK_LAST  = CW'(BLANK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_OFF, S_ONES, S_BLK_O, S_TENS, S_BLK_T
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [6:0]    sh_tens, sh_tens_nxt;
  logic [6:0]    sh_ones, sh_ones_nxt;
  logic          sh_blz, sh_blz_nxt;
  logic          enter, capture, tens_blank;
  logic [6:0]    seg_h;
  logic [1:0]    an_h;
  logic          fd_nxt;
  logic [6:0]    seg_q;
  logic [1:0]    an_q;
  logic          fd_q;

  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    unique case (state)
      S_OFF: begin
        state_nxt = S_ONES;
        enter     = 1'b1;
      end
      S_ONES: if (cnt == TICK_LAST) begin
        state_nxt = HAS_BLK ? S_BLK_O : S_TENS;
        enter     = 1'b1;
      end
      S_BLK_O: if (cnt == BLK_LAST) begin
        state_nxt = S_TENS;
        enter     = 1'b1;
      end
      S_TENS: if (cnt == TICK_LAST) begin
        state_nxt = HAS_BLK ? S_BLK_T : S_ONES;
        enter     = 1'b1;
      end
      S_BLK_T: if (cnt == BLK_LAST) begin
        state_nxt = S_ONES;
        enter     = 1'b1;
      end
      default: begin
        state_nxt = S_OFF;
        enter     = 1'b1;
      end
    endcase
    // disable aborts the frame from any state
    if (!bus.enable) begin
      state_nxt = S_OFF;
      enter     = 1'b1;
    end

    cnt_nxt = enter ? '0 : cnt + CW'(1);
    capture = enter && (state_nxt == S_ONES);

    sh_tens_nxt = capture ? bus.seg_tens : sh_tens;
    sh_ones_nxt = capture ? bus.seg_ones : sh_ones;
    sh_blz_nxt  = capture ? bus.blank_lz : sh_blz;
    tens_blank  = sh_blz_nxt && (sh_tens_nxt == 7'h3F);

    seg_h = '0;
    an_h  = '0;
    unique case (1'b1)
      state_nxt == S_ONES: begin
        seg_h = sh_ones_nxt;
        an_h  = 2'b01;
      end
      state_nxt == S_TENS && !tens_blank: begin
        seg_h = sh_tens_nxt;
        an_h  = 2'b10;
      end
      default: ;
    endcase

    if (HAS_BLK)
      fd_nxt = (state_nxt == S_BLK_T) && (cnt_nxt == BLK_LAST);
    else
      fd_nxt = (state_nxt == S_TENS) && (cnt_nxt == TICK_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_OFF;
      cnt     <= '0;
      sh_tens <= '0;
      sh_ones <= '0;
      sh_blz  <= 1'b0;
      seg_q   <= {7{SEG_ACTIVE_LOW}};
      an_q    <= {2{AN_ACTIVE_LOW}};
      fd_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sh_tens <= sh_tens_nxt;
      sh_ones <= sh_ones_nxt;
      sh_blz  <= sh_blz_nxt;
      seg_q   <= seg_h ^ {7{SEG_ACTIVE_LOW}};
      an_q    <= an_h ^ {2{AN_ACTIVE_LOW}};
      fd_q    <= fd_nxt;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.an_out     = an_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan: active-low unit with dead-time
// and an active-high gapless unit side by side.
module tb_seg_display_scan;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seg_display_scan_if ifa ();
  seg_display_scan_if ifb ();

  seg_display_scan #(
    .TICK_DIV(4), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );

  seg_display_scan #(
    .TICK_DIV(4), .BLANK_CYCLES(0),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  // Expected {seg,an,fd} for cycle i of a 12-cycle active-low frame
  function automatic logic [9:0] exp_a(
    int i, logic [6:0] so, logic [6:0] st, logic tblank
  );
    int k;
    logic [6:0] s;
    logic [1:0] a;
    k = i % 12;
    s = 7'h7F;
    a = 2'b11;
    if (k < 4) begin
      s = ~so;
      a = 2'b10;
    end else if (k >= 6 && k < 10 && !tblank) begin
      s = ~st;
      a = 2'b01;
    end
    return {s, a, (k == 11)};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({ifa.seg_out, ifa.an_out, ifa.frame_done}
          !== {7'h7F, 2'b11, 1'b0}) begin
        errors++;
        $display("FAIL reset cyc %0d: got seg=%h an=%b fd=%b, want seg=7f an=11 fd=0",
                 i, ifa.seg_out, ifa.an_out, ifa.frame_done);
      end
    end
  endtask

  task automatic test_scan();
    logic [9:0] e;
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      e = exp_a(i, 7'h5B, 7'h06, 1'b0);
      checks++;
      if ({ifa.seg_out, ifa.an_out, ifa.frame_done} !== e) begin
        errors++;
        $display("FAIL scan cyc %0d: got %h/%b/%b want %h/%b/%b",
                 i, ifa.seg_out, ifa.an_out, ifa.frame_done,
                 e[9:3], e[2:1], e[0]);
      end
    end
  endtask

  task automatic test_blank_lz();
    logic [9:0] e;
    ifa.seg_tens = 7'h3F;
    for (int p = 0; p < 2; p++) begin
      ifa.blank_lz = (p == 0);
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        e = exp_a(i, 7'h5B, 7'h3F, (p == 0));
        checks++;
        if ({ifa.seg_out, ifa.an_out, ifa.frame_done} !== e) begin
          errors++;
          $display("FAIL blank_lz=%0d cyc %0d: got %h/%b/%b want %h/%b/%b",
                   (p == 0), i, ifa.seg_out, ifa.an_out,
                   ifa.frame_done, e[9:3], e[2:1], e[0]);
        end
      end
    end
  endtask

  task automatic test_shadow();
    logic [9:0] e;
    ifa.seg_tens = 7'h06;
    ifa.seg_ones = 7'h5B;
    ifa.blank_lz = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      e = exp_a(i, (i < 12) ? 7'h5B : 7'h4F, 7'h06, 1'b0);
      checks++;
      if ({ifa.seg_out, ifa.an_out, ifa.frame_done} !== e) begin
        errors++;
        $display("FAIL shadow cyc %0d: got %h/%b/%b want %h/%b/%b",
                 i, ifa.seg_out, ifa.an_out, ifa.frame_done,
                 e[9:3], e[2:1], e[0]);
      end
      if (i == 6) ifa.seg_ones = 7'h4F;
    end
  endtask

  task automatic test_abort();
    logic [9:0] e;
    ifa.seg_ones = 7'h5B;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        e = exp_a(i, 7'h5B, 7'h06, 1'b0);
        checks++;
        if ({ifa.seg_out, ifa.an_out, ifa.frame_done} !== e) begin
          errors++;
          $display("FAIL abort%0d pre cyc %0d: got %h/%b/%b want %h/%b/%b",
                   r, i, ifa.seg_out, ifa.an_out, ifa.frame_done,
                   e[9:3], e[2:1], e[0]);
        end
      end
      if (r == 0) ifa.enable = 1'b0;
      else rst_n = 1'b0;
      for (int i = 0; i < ((r == 0) ? 3 : 1); i++) begin
        @(negedge clk);
        checks++;
        if ({ifa.seg_out, ifa.an_out, ifa.frame_done}
            !== {7'h7F, 2'b11, 1'b0}) begin
          errors++;
          $display("FAIL abort%0d off cyc %0d: got %h/%b/%b want 7f/11/0",
                   r, i, ifa.seg_out, ifa.an_out, ifa.frame_done);
        end
      end
      ifa.enable = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        e = exp_a(i, 7'h5B, 7'h06, 1'b0);
        checks++;
        if ({ifa.seg_out, ifa.an_out, ifa.frame_done} !== e) begin
          errors++;
          $display("FAIL abort%0d resume cyc %0d: got %h/%b/%b want %h/%b/%b",
                   r, i, ifa.seg_out, ifa.an_out, ifa.frame_done,
                   e[9:3], e[2:1], e[0]);
        end
      end
    end
  endtask

  task automatic test_no_gap();
    logic [6:0] es;
    logic [1:0] ea;
    logic       ef;
    ifb.enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      es = ((i % 8) < 4) ? 7'h5B : 7'h06;
      ea = ((i % 8) < 4) ? 2'b01 : 2'b10;
      ef = ((i % 8) == 7);
      checks++;
      if ({ifb.seg_out, ifb.an_out, ifb.frame_done} !== {es, ea, ef}) begin
        errors++;
        $display("FAIL no_gap cyc %0d: got %h/%b/%b want %h/%b/%b",
                 i, ifb.seg_out, ifb.an_out, ifb.frame_done, es, ea, ef);
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    ifa.enable   = 1'b1;
    ifa.blank_lz = 1'b0;
    ifa.seg_tens = 7'h06;
    ifa.seg_ones = 7'h5B;
    ifb.enable   = 1'b0;
    ifb.blank_lz = 1'b0;
    ifb.seg_tens = 7'h06;
    ifb.seg_ones = 7'h5B;
    test_reset();
    test_scan();
    test_blank_lz();
    test_shadow();
    test_abort();
    test_no_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
